// File: rtl/pipe_ctrl_n.sv
// rtl/pipe_ctrl_n.sv - N-stage pipeline hold/bubble/flush controller with exception redirect engine
module pipe_ctrl_n #(
    parameter int          STAGES     = 5,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
    parameter int          CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STAGES-1:0] stallreq,
    input  logic              exc_valid,
    input  logic              exc_is_eret,
    input  logic [31:0]       exc_epc,
    input  logic              perf_clr,
    output logic [STAGES-1:0] stall,
    output logic [STAGES-1:0] bubble,
    output logic [STAGES-1:0] flush,
    output logic              redirect_valid,
    output logic [31:0]       redirect_pc,
    output logic              busy,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {IDLE, FLUSH, REDIR} state_t;

    state_t            state;
    logic [STAGES-1:0] held;
    logic [STAGES-1:0] gap;
    logic [STAGES-1:0] flush_q;
    logic              busy_q;
    logic              redirect_q;
    logic              any_req;
    logic              run;
    logic              acc;

    assign any_req = |stallreq;
    // Stall control only applies in IDLE and is forced quiet while reset is asserted.
    assign run     = rst && (state == IDLE);

    // A hold at stage k must also hold every upstream register; the first
    // register past the highest holder receives a bubble.
    always_comb begin
        acc  = 1'b0;
        held = '0;
        gap  = '0;
        for (int j = STAGES - 1; j >= 0; j--) begin
            acc     = acc | stallreq[j];
            held[j] = acc;
        end
        for (int j = 1; j < STAGES; j++) begin
            gap[j] = held[j-1] & ~held[j];
        end
    end

    assign stall          = run ? held : '0;
    assign bubble         = run ? gap  : '0;
    assign flush          = flush_q;
    assign busy           = busy_q;
    assign redirect_valid = redirect_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            redirect_pc <= 32'h0;
            flush_q     <= '0;
            busy_q      <= 1'b0;
            redirect_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    redirect_q <= 1'b0;
                    if (exc_valid) begin
                        state       <= FLUSH;
                        redirect_pc <= exc_is_eret ? exc_epc : EXC_VECTOR;
                        flush_q     <= '1;
                        busy_q      <= 1'b1;
                    end else begin
                        flush_q <= '0;
                        busy_q  <= 1'b0;
                    end
                end
                FLUSH: begin
                    // PC register keeps its slot so IF can load the redirect target.
                    state      <= REDIR;
                    flush_q    <= {{(STAGES-1){1'b1}}, 1'b0};
                    busy_q     <= 1'b1;
                    redirect_q <= 1'b1;
                end
                default: begin
                    state      <= IDLE;
                    flush_q    <= '0;
                    busy_q     <= 1'b0;
                    redirect_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (perf_clr) begin
            stall_cnt <= '0;
        end else if (state == IDLE && any_req && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl_n.sv
// tb/tb_pipe_ctrl_n.sv - randomized and directed checks of pipe_ctrl_n against a phase-based model
module tb_pipe_ctrl_n;

    localparam int          S     = 5;
    localparam int          CW    = 4;
    localparam logic [31:0] EVEC  = 32'hBFC00380;
    localparam int          CMAX  = 15;

    logic          clk;
    logic          rst;
    logic [S-1:0]  stallreq;
    logic          exc_valid;
    logic          exc_is_eret;
    logic [31:0]   exc_epc;
    logic          perf_clr;
    logic [S-1:0]  stall;
    logic [S-1:0]  bubble;
    logic [S-1:0]  flush;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          busy;
    logic [CW-1:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    // Model: phase counts cycles since an exception was accepted (0 = none).
    int          m_phase;
    logic [31:0] m_pc;
    int          m_cnt;
    int          pulses;

    pipe_ctrl_n #(.STAGES(S), .EXC_VECTOR(EVEC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .stallreq(stallreq), .exc_valid(exc_valid),
        .exc_is_eret(exc_is_eret), .exc_epc(exc_epc), .perf_clr(perf_clr),
        .stall(stall), .bubble(bubble), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .busy(busy), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase = 0;
            m_pc    = 32'h0;
            m_cnt   = 0;
        end else begin
            if (perf_clr) m_cnt = 0;
            else if (m_phase == 0 && stallreq != 0 && m_cnt < CMAX) m_cnt = m_cnt + 1;
            if (m_phase == 0) begin
                if (exc_valid) begin
                    m_phase = 1;
                    m_pc    = exc_is_eret ? exc_epc : EVEC;
                end
            end else if (m_phase == 1) begin
                m_phase = 2;
            end else begin
                m_phase = 0;
            end
        end
    end

    always @(negedge clk) begin
        logic [S-1:0] es, eb, ef;
        int k;
        es = '0; eb = '0; ef = '0;
        if (rst && m_phase == 0) begin
            k = -1;
            for (int j = 0; j < S; j++) if (stallreq[j]) k = j;
            for (int j = 0; j < S; j++) if (j <= k) es[j] = 1'b1;
            if (k >= 0 && k + 1 < S) eb[k+1] = 1'b1;
        end
        if (m_phase == 1) ef = '1;
        if (m_phase == 2) begin
            ef = '1;
            ef[0] = 1'b0;
        end
        chk("m_stall", stall, es);
        chk("m_bubble", bubble, eb);
        chk("m_flush", flush, ef);
        chk("m_redirect_valid", redirect_valid, m_phase == 2);
        chk("m_redirect_pc", redirect_pc, m_pc);
        chk("m_busy", busy, m_phase != 0);
        chk("m_stall_cnt", stall_cnt, m_cnt);
        if (redirect_valid) pulses++;
    end

    task automatic cyc(input logic [S-1:0] sr, input logic ev, input logic er,
                       input logic [31:0] epc, input logic pc);
        @(posedge clk);
        #2;
        stallreq    = sr;
        exc_valid   = ev;
        exc_is_eret = er;
        exc_epc     = epc;
        perf_clr    = pc;
    endtask

    initial begin
        pulses      = 0;
        rst         = 1'b0;
        stallreq    = 5'b11111;
        exc_valid   = 1'b1;
        exc_is_eret = 1'b0;
        exc_epc     = 32'h0;
        perf_clr    = 1'b0;

        // Reset held with everything asserted
        repeat (3) begin
            @(negedge clk);
            chk("rst_stall", stall, 0);
            chk("rst_busy", busy, 0);
            chk("rst_cnt", stall_cnt, 0);
            chk("rst_flush", flush, 0);
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        stallreq = '0; exc_valid = 1'b0;
        @(negedge clk);
        chk("rst_idle_busy", busy, 0);

        // Stall encodings
        cyc(5'b00010, 0, 0, 0, 0);
        @(negedge clk);
        chk("enc1_stall", stall, 5'b00011);
        chk("enc1_bubble", bubble, 5'b00100);
        cyc(5'b01010, 0, 0, 0, 0);
        @(negedge clk);
        chk("enc2_stall", stall, 5'b01111);
        chk("enc2_bubble", bubble, 5'b10000);
        cyc(5'b10000, 0, 0, 0, 0);
        @(negedge clk);
        chk("enc3_stall", stall, 5'b11111);
        chk("enc3_bubble", bubble, 5'b00000);

        // Plain exception
        cyc(5'b00000, 1, 0, 32'hDEAD_BEEF, 0);
        cyc(5'b00000, 0, 0, 0, 0);
        @(negedge clk);
        chk("exc_n1_flush", flush, 5'b11111);
        chk("exc_n1_busy", busy, 1);
        cyc(5'b00000, 0, 0, 0, 0);
        @(negedge clk);
        chk("exc_n2_rv", redirect_valid, 1);
        chk("exc_n2_pc", redirect_pc, 32'hBFC00380);
        chk("exc_n2_flush", flush, 5'b11110);
        cyc(5'b00000, 0, 0, 0, 0);
        @(negedge clk);
        chk("exc_n3_busy", busy, 0);

        // ERET colliding with a stall request, second exception during FLUSH
        cyc(5'b00000, 0, 0, 0, 1);
        pulses = 0;
        cyc(5'b00100, 1, 1, 32'h8000_1234, 0);
        cyc(5'b00100, 1, 0, 32'h0, 0);
        @(negedge clk);
        chk("eret_flush_cnt", stall_cnt, 1);
        chk("eret_flush_stall", stall, 0);
        cyc(5'b00100, 0, 0, 0, 0);
        @(negedge clk);
        chk("eret_pc", redirect_pc, 32'h8000_1234);
        chk("eret_redir_cnt", stall_cnt, 1);
        cyc(5'b00000, 0, 0, 0, 0);
        cyc(5'b00000, 0, 0, 0, 0);
        cyc(5'b00000, 0, 0, 0, 0);
        @(negedge clk);
        chk("eret_pulses", pulses, 1);
        chk("eret_idle_cnt", stall_cnt, 1);

        // Saturation and clear
        repeat (20) cyc(5'b01000, 0, 0, 0, 0);
        cyc(5'b01000, 0, 0, 0, 1);
        @(negedge clk);
        chk("sat_cnt", stall_cnt, 15);
        cyc(5'b01000, 0, 0, 0, 0);
        @(negedge clk);
        chk("clr_cnt", stall_cnt, 0);
        cyc(5'b00000, 0, 0, 0, 0);
        @(negedge clk);
        chk("clr_then_inc", stall_cnt, 1);

        // Asynchronous reset in the middle of FLUSH
        cyc(5'b00000, 1, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("mid_flush_before", flush, 5'b11111);
        #2;
        exc_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("mid_flush_after", flush, 0);
        chk("mid_busy_after", busy, 0);
        pulses = 0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        repeat (4) cyc(5'b00000, 0, 0, 0, 0);
        @(negedge clk);
        chk("mid_no_pulse", pulses, 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 31), ($urandom_range(0, 7) == 0),
                $urandom_range(0, 1), $urandom, ($urandom_range(0, 15) == 0));
            if ($urandom_range(0, 63) == 0) rst = 1'b0;
            else rst = 1'b1;
        end
        rst = 1'b1;
        repeat (3) cyc(5'b00000, 0, 0, 0, 0);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
